// File: rtl/spi_slave_pkg.sv
// Shared SPI types: mode, frame size, bit order, config record and slave FSM states.
package spi_slave_pkg;

  typedef enum logic [1:0] {
    SPI_MODE_0 = 2'b00,
    SPI_MODE_1 = 2'b01,
    SPI_MODE_2 = 2'b10,
    SPI_MODE_3 = 2'b11
  } spi_mode_t;

  typedef enum logic [1:0] {
    SPI_FRAME_SIZE_8  = 2'd0,
    SPI_FRAME_SIZE_16 = 2'd1,
    SPI_FRAME_SIZE_32 = 2'd2
  } spi_frame_size_t;

  typedef enum logic {
    MSB_FIRST = 1'b0,
    LSB_FIRST = 1'b1
  } bit_order_t;

  typedef enum logic [2:0] {
    PSC_2, PSC_4, PSC_8, PSC_16, PSC_32, PSC_64, PSC_128, PSC_256
  } spi_prescaler_t;

  typedef struct packed {
    spi_mode_t       spi_mode;
    spi_frame_size_t spi_frame_size;
    bit_order_t      bit_order;
    spi_prescaler_t  prescaler;
  } spi_config_t;

  typedef enum logic {
    SPI_SLV_IDLE,
    SPI_SLV_ACTIVE
  } spi_slv_state_t;

  // Frame length in bits; the unused encoding falls back to 32.
  function automatic logic [5:0] frame_len(spi_frame_size_t fs);
    case (fs)
      SPI_FRAME_SIZE_8:  return 6'd8;
      SPI_FRAME_SIZE_16: return 6'd16;
      default:           return 6'd32;
    endcase
  endfunction

  // Right-aligned mask covering one frame.
  function automatic logic [31:0] frame_mask(spi_frame_size_t fs);
    case (fs)
      SPI_FRAME_SIZE_8:  return 32'h0000_00FF;
      SPI_FRAME_SIZE_16: return 32'h0000_FFFF;
      default:           return 32'hFFFF_FFFF;
    endcase
  endfunction

endpackage

// File: rtl/spi_slave_sync.sv
// Three-flop synchronizer with configurable reset level and edge pulses.
module sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);

  logic [2:0] sync_q;

  // Two metastability stages plus one history stage for edge detection.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) sync_q <= {3{RST_VAL}};
    else          sync_q <= {sync_q[1:0], d_i};
  end

  assign rise_o =  sync_q[1] & ~sync_q[2];
  assign fall_o = ~sync_q[1] &  sync_q[2];

endmodule

// File: rtl/spi_slave.sv
// SPI target: synchronizes sclk/cs_n/mosi into clk, shifts tx_data out on miso
// and assembles the received frame into rx_data, with pulse handshakes.
module spi_slave
  import spi_slave_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  spi_config_t spi_config,
  input  logic        sclk,
  input  logic        cs_n,
  input  logic        mosi,
  output logic        miso,
  output logic        miso_oe,
  input  logic [31:0] tx_data,
  output logic        tx_ack,
  output logic [31:0] rx_data,
  output logic        rx_valid,
  output logic        frame_err,
  output logic        busy
);

  spi_slv_state_t  state_q, state_d;
  spi_mode_t       mode_q, mode_d;
  spi_frame_size_t size_q, size_d;
  bit_order_t      order_q, order_d;
  logic [31:0]     tx_shift_q, tx_shift_d;
  logic [31:0]     rx_shift_q, rx_shift_d;
  logic [5:0]      bit_cnt_q, bit_cnt_d;
  logic            miso_q, miso_d;
  logic [31:0]     rx_data_q, rx_data_d;
  logic            rx_valid_q, rx_valid_d;
  logic            tx_ack_q, tx_ack_d;
  logic            frame_err_q, frame_err_d;
  logic [1:0]      mosi_sync_q;

  logic sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic mosi_s;
  logic cpol, cpha, lead_edge, trail_edge, sample_edge, shift_edge;
  spi_frame_size_t cur_size;
  bit_order_t      cur_order;
  logic [5:0]  cur_len;
  logic [4:0]  cur_top;
  logic [31:0] cur_mask;
  logic [31:0] tx_load, tx_next, rx_next;
  logic        first_bit;
  logic [5:0]  cnt_next;
  logic        unused_cfg;

  assign unused_cfg = ^spi_config.prescaler;

  sync_edge #(.RST_VAL(1'b0)) u_sclk_sync (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .d_i     (sclk),
    .rise_o  (sclk_rise),
    .fall_o  (sclk_fall)
  );

  sync_edge #(.RST_VAL(1'b1)) u_cs_sync (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .d_i     (cs_n),
    .rise_o  (cs_rise),
    .fall_o  (cs_fall)
  );

  // Two-flop mosi chain keeps data aligned with the sclk edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mosi_sync_q <= '0;
    else        mosi_sync_q <= {mosi_sync_q[0], mosi};
  end
  assign mosi_s = mosi_sync_q[1];

  // Edge roles come from the latched mode.
  assign cpol        = mode_q[1];
  assign cpha        = mode_q[0];
  assign lead_edge   = cpol ? sclk_fall : sclk_rise;
  assign trail_edge  = cpol ? sclk_rise : sclk_fall;
  assign sample_edge = cpha ? trail_edge : lead_edge;
  assign shift_edge  = cpha ? lead_edge  : trail_edge;

  // In IDLE the live config governs the first load; once ACTIVE the latched copy rules.
  assign cur_size  = (state_q == SPI_SLV_IDLE) ? spi_config.spi_frame_size : size_q;
  assign cur_order = (state_q == SPI_SLV_IDLE) ? spi_config.bit_order      : order_q;
  assign cur_len   = frame_len(cur_size);
  assign cur_top   = 5'(cur_len - 6'd1);
  assign cur_mask  = frame_mask(cur_size);

  assign tx_load   = tx_data & cur_mask;
  assign first_bit = (cur_order == MSB_FIRST) ? tx_data[cur_top] : tx_data[0];
  assign tx_next   = (cur_order == MSB_FIRST) ? (tx_shift_q << 1) : (tx_shift_q >> 1);
  assign rx_next   = (cur_order == MSB_FIRST) ? {rx_shift_q[30:0], mosi_s}
                                              : ((rx_shift_q >> 1) | ({31'b0, mosi_s} << cur_top));
  assign cnt_next  = bit_cnt_q + 6'd1;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= SPI_SLV_IDLE;
    else        state_q <= state_d;
  end

  // Next-state: select opens a frame, deselect closes it regardless of sclk activity.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      SPI_SLV_IDLE:   if (cs_fall) state_d = SPI_SLV_ACTIVE;
      SPI_SLV_ACTIVE: if (cs_rise) state_d = SPI_SLV_IDLE;
      default:        state_d = SPI_SLV_IDLE;
    endcase
  end

  // Datapath next-state; cs_n rise outranks any sclk edge seen in the same cycle.
  always_comb begin
    mode_d      = mode_q;
    size_d      = size_q;
    order_d     = order_q;
    tx_shift_d  = tx_shift_q;
    rx_shift_d  = rx_shift_q;
    bit_cnt_d   = bit_cnt_q;
    miso_d      = miso_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    tx_ack_d    = 1'b0;
    frame_err_d = 1'b0;
    unique case (state_q)
      SPI_SLV_IDLE: begin
        if (cs_fall) begin
          mode_d     = spi_config.spi_mode;
          size_d     = spi_config.spi_frame_size;
          order_d    = spi_config.bit_order;
          tx_shift_d = tx_load;
          miso_d     = first_bit;
          tx_ack_d   = 1'b1;
          bit_cnt_d  = '0;
          rx_shift_d = '0;
        end
      end
      SPI_SLV_ACTIVE: begin
        if (cs_rise) begin
          frame_err_d = (bit_cnt_q != '0);
          bit_cnt_d   = '0;
          rx_shift_d  = '0;
          miso_d      = 1'b0;
        end else if (sample_edge) begin
          if (cnt_next == cur_len) begin
            rx_data_d  = rx_next & cur_mask;
            rx_valid_d = 1'b1;
            bit_cnt_d  = '0;
            rx_shift_d = '0;
            tx_shift_d = tx_load;
            miso_d     = first_bit;
            tx_ack_d   = 1'b1;
          end else begin
            rx_shift_d = rx_next;
            bit_cnt_d  = cnt_next;
          end
        end else if (shift_edge && (bit_cnt_q != '0)) begin
          tx_shift_d = tx_next;
          miso_d     = (cur_order == MSB_FIRST) ? tx_next[cur_top] : tx_next[0];
        end
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q      <= SPI_MODE_0;
      size_q      <= SPI_FRAME_SIZE_8;
      order_q     <= MSB_FIRST;
      tx_shift_q  <= '0;
      rx_shift_q  <= '0;
      bit_cnt_q   <= '0;
      miso_q      <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      tx_ack_q    <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      mode_q      <= mode_d;
      size_q      <= size_d;
      order_q     <= order_d;
      tx_shift_q  <= tx_shift_d;
      rx_shift_q  <= rx_shift_d;
      bit_cnt_q   <= bit_cnt_d;
      miso_q      <= miso_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      tx_ack_q    <= tx_ack_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Outputs: selection status from state, everything else straight from registers.
  always_comb begin
    busy      = (state_q == SPI_SLV_ACTIVE);
    miso_oe   = (state_q == SPI_SLV_ACTIVE);
    miso      = miso_q;
    rx_data   = rx_data_q;
    rx_valid  = rx_valid_q;
    tx_ack    = tx_ack_q;
    frame_err = frame_err_q;
  end

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: a behavioural SPI master drives the pins,
// expected words come from plain masking of the words exchanged.
module tb_spi_slave;
  import spi_slave_pkg::*;

  localparam int HP = 6;  // sclk half-period in clk cycles

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  spi_config_t spi_config;
  logic        sclk = 1'b0, cs_n = 1'b1, mosi = 1'b0;
  logic        miso, miso_oe, tx_ack, rx_valid, frame_err, busy;
  logic [31:0] tx_data = '0;
  logic [31:0] rx_data;

  int checks = 0, failures = 0;
  int n_ferr = 0, n_rxv_alone = 0;
  logic [31:0] cap_q[$];
  logic [31:0] rxq[$];
  logic [31:0] load_val = '0;
  int          load_seq = 0, seen_seq = 0;
  logic [31:0] exp_rx = '0;
  logic        cur_cpol = 1'b0, cur_cpha = 1'b0, cur_lsb = 1'b0;
  int          cur_n = 8;

  always #5 clk = ~clk;

  spi_slave dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .spi_config (spi_config),
    .sclk       (sclk),
    .cs_n       (cs_n),
    .mosi       (mosi),
    .miso       (miso),
    .miso_oe    (miso_oe),
    .tx_data    (tx_data),
    .tx_ack     (tx_ack),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  // Host side: logs pulses, records captured tx words, refreshes tx_data after each ack.
  always @(negedge clk) begin
    if (rx_valid === 1'b1) begin
      rxq.push_back(rx_data);
      if (tx_ack !== 1'b1) n_rxv_alone++;
    end
    if (frame_err === 1'b1) n_ferr++;
    if (tx_ack === 1'b1) begin
      cap_q.push_back(tx_data);
      tx_data = $urandom;
    end else if (seen_seq != load_seq) begin
      tx_data  = load_val;
      seen_seq = load_seq;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: time limit reached, checks=%0d", checks);
    $fatal(1);
  end

  function automatic logic [31:0] wmask(input int n);
    return (n >= 32) ? 32'hFFFF_FFFF : ((32'h1 << n) - 32'h1);
  endfunction

  function automatic spi_config_t mk_cfg(input int mode, input int n, input bit lsb);
    spi_config_t c;
    logic [1:0]  m;
    m = mode[1:0];
    c.spi_mode       = spi_mode_t'(m);
    c.spi_frame_size = (n == 8) ? SPI_FRAME_SIZE_8 : (n == 16) ? SPI_FRAME_SIZE_16 : SPI_FRAME_SIZE_32;
    c.bit_order      = lsb ? LSB_FIRST : MSB_FIRST;
    c.prescaler      = PSC_8;
    return c;
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_tx(input logic [31:0] v);
    load_val = v;
    load_seq++;
    wait_clk(2);
  endtask

  task automatic do_reset(input logic lvl);
    rst_n = 1'b0;
    cs_n  = 1'b1;
    sclk  = lvl;
    mosi  = 1'b0;
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(4);
    exp_rx = '0;
  endtask

  task automatic select(input int mode, input int n, input bit lsb);
    cur_cpol   = mode[1];
    cur_cpha   = mode[0];
    cur_lsb    = lsb;
    cur_n      = n;
    spi_config = mk_cfg(mode, n, lsb);
    sclk       = cur_cpol;
    mosi       = 1'b0;
    wait_clk(3);
    cs_n = 1'b0;
    wait_clk(HP);
  endtask

  task automatic deselect();
    wait_clk(HP);
    cs_n = 1'b1;
    wait_clk(4);
  endtask

  // Master side: exchanges nbits of one frame, returning what it saw on miso.
  task automatic clock_bits(input logic [31:0] mw, input int nbits, output logic [31:0] mr);
    int bi;
    mr = '0;
    for (int i = 0; i < nbits; i++) begin
      bi = cur_lsb ? i : (cur_n - 1 - i);
      if (!cur_cpha) begin
        mosi = mw[bi];
        wait_clk(HP);
        mr[bi] = miso;
        sclk = ~cur_cpol;
        wait_clk(HP);
        sclk = cur_cpol;
      end else begin
        sclk = ~cur_cpol;
        mosi = mw[bi];
        wait_clk(HP);
        mr[bi] = miso;
        sclk = cur_cpol;
        wait_clk(HP);
      end
    end
  endtask

  task automatic run_single_frame(input string tag, input int mode, input int n, input bit lsb,
                                  input logic [31:0] mw, input logic [31:0] tw, input bit scramble);
    logic [31:0] mr, m, got;
    logic [7:0]  r;
    int cb, rb, fb, ab;
    m = wmask(n);
    set_tx(tw);
    cb = cap_q.size(); rb = rxq.size(); fb = n_ferr; ab = n_rxv_alone;
    select(mode, n, lsb);
    checks++;
    if (busy !== 1'b1 || miso_oe !== 1'b1) begin
      failures++;
      $display("FAIL %s selected: busy=%b miso_oe=%b required 1/1", tag, busy, miso_oe);
    end
    if (scramble) begin
      r = 8'($urandom);
      spi_config = spi_config_t'(r);
    end
    clock_bits(mw, n, mr);
    deselect();
    checks++;
    if (mr !== (tw & m)) begin
      failures++;
      $display("FAIL %s master_rx: got %h required %h", tag, mr, tw & m);
    end
    checks++;
    if (rxq.size() - rb != 1) begin
      failures++;
      $display("FAIL %s rx_valid_count: got %0d required 1", tag, rxq.size() - rb);
    end
    got = (rxq.size() > rb) ? rxq[rb] : 32'hxxxx_xxxx;
    checks++;
    if (got !== (mw & m)) begin
      failures++;
      $display("FAIL %s rx_data_at_valid: got %h required %h", tag, got, mw & m);
    end
    checks++;
    if (rx_data !== (mw & m)) begin
      failures++;
      $display("FAIL %s rx_data_held: got %h required %h", tag, rx_data, mw & m);
    end
    checks++;
    if (cap_q.size() - cb != 2) begin
      failures++;
      $display("FAIL %s tx_ack_count: got %0d required 2", tag, cap_q.size() - cb);
    end
    checks++;
    if (n_ferr != fb || n_rxv_alone != ab) begin
      failures++;
      $display("FAIL %s stray_pulses: frame_err=%0d lone_rx_valid=%0d required 0/0", tag, n_ferr - fb, n_rxv_alone - ab);
    end
    checks++;
    if (busy !== 1'b0 || miso_oe !== 1'b0 || miso !== 1'b0) begin
      failures++;
      $display("FAIL %s deselected: busy=%b miso_oe=%b miso=%b required 0/0/0", tag, busy, miso_oe, miso);
    end
    exp_rx = mw & m;
  endtask

  task automatic test_reset();
    wait_clk(2);
    checks++;
    if ({miso, miso_oe, busy, rx_valid, tx_ack, frame_err} !== 6'b0 || rx_data !== 32'h0) begin
      failures++;
      $display("FAIL reset_hold: outs=%b rx_data=%h required 000000/00000000",
               {miso, miso_oe, busy, rx_valid, tx_ack, frame_err}, rx_data);
    end
    rst_n = 1'b1;
    wait_clk(4);
    checks++;
    if ({miso, miso_oe, busy, rx_valid, tx_ack, frame_err} !== 6'b0 || rx_data !== 32'h0) begin
      failures++;
      $display("FAIL reset_release: outs=%b rx_data=%h required 000000/00000000",
               {miso, miso_oe, busy, rx_valid, tx_ack, frame_err}, rx_data);
    end
    checks++;
    if (cap_q.size() != 0 || rxq.size() != 0 || n_ferr != 0) begin
      failures++;
      $display("FAIL reset_pulses: ack=%0d valid=%0d err=%0d required 0/0/0", cap_q.size(), rxq.size(), n_ferr);
    end
  endtask

  task automatic test_mode0();
    run_single_frame("mode0_8b", 0, 8, 1'b0, 32'h72, 32'hA5, 1'b0);
  endtask

  task automatic test_modes_16();
    for (int m = 1; m <= 3; m++) begin
      do_reset(m >= 2);
      run_single_frame($sformatf("mode%0d_16b", m), m, 16, 1'b0, 32'h1234, 32'hBEEF, 1'b0);
    end
  endtask

  task automatic test_lsb32();
    run_single_frame("lsb_32b_m0", 0, 32, 1'b1, 32'h8000_0001, 32'hDEAD_BEEF, 1'b0);
    run_single_frame("lsb_32b_m3", 3, 32, 1'b1, $urandom, $urandom, 1'b0);
  endtask

  task automatic test_random();
    int n, mode;
    bit lsb;
    for (int i = 0; i < 8; i++) begin
      mode = $urandom_range(0, 3);
      n    = 8 << $urandom_range(0, 2);
      lsb  = 1'($urandom_range(0, 1));
      run_single_frame($sformatf("rand%0d_m%0d_n%0d_l%0d", i, mode, n, lsb), mode, n, lsb,
                       $urandom, $urandom, 1'b1);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] tw, mr1, mr2, e2, g1, g2;
    int cb, rb, fb, ab, m;
    for (int k = 0; k < 2; k++) begin
      m  = k * 3;
      tw = $urandom;
      set_tx(tw);
      cb = cap_q.size(); rb = rxq.size(); fb = n_ferr; ab = n_rxv_alone;
      select(m, 8, 1'b0);
      clock_bits(32'h11, 8, mr1);
      clock_bits(32'h22, 8, mr2);
      deselect();
      checks++;
      if (rxq.size() - rb != 2) begin
        failures++;
        $display("FAIL b2b_m%0d rx_valid_count: got %0d required 2", m, rxq.size() - rb);
      end
      g1 = (rxq.size() > rb)     ? rxq[rb]     : 32'hxxxx_xxxx;
      g2 = (rxq.size() > rb + 1) ? rxq[rb + 1] : 32'hxxxx_xxxx;
      checks++;
      if (g1 !== 32'h11 || g2 !== 32'h22) begin
        failures++;
        $display("FAIL b2b_m%0d rx_sequence: got %h,%h required 00000011,00000022", m, g1, g2);
      end
      checks++;
      if (mr1 !== (tw & 32'hFF)) begin
        failures++;
        $display("FAIL b2b_m%0d miso_frame1: got %h required %h", m, mr1, tw & 32'hFF);
      end
      e2 = (cap_q.size() > cb + 1) ? (cap_q[cb + 1] & 32'hFF) : 32'hxxxx_xxxx;
      checks++;
      if (mr2 !== e2) begin
        failures++;
        $display("FAIL b2b_m%0d miso_frame2: got %h required %h", m, mr2, e2);
      end
      checks++;
      if (cap_q.size() - cb != 3 || n_rxv_alone != ab || n_ferr != fb) begin
        failures++;
        $display("FAIL b2b_m%0d pulses: acks=%0d lone_valid=%0d err=%0d required 3/0/0",
                 m, cap_q.size() - cb, n_rxv_alone - ab, n_ferr - fb);
      end
      exp_rx = 32'h22;
    end
  endtask

  task automatic test_abort();
    logic [31:0] prior, mr;
    int cb, rb, fb;
    prior = exp_rx;
    set_tx($urandom);
    cb = cap_q.size(); rb = rxq.size(); fb = n_ferr;
    select(0, 8, 1'b0);
    clock_bits($urandom, 3, mr);
    deselect();
    checks++;
    if (n_ferr - fb != 1) begin
      failures++;
      $display("FAIL abort frame_err_count: got %0d required 1", n_ferr - fb);
    end
    checks++;
    if (rxq.size() != rb || rx_data !== prior) begin
      failures++;
      $display("FAIL abort rx_kept: valid=%0d rx_data=%h required 0/%h", rxq.size() - rb, rx_data, prior);
    end
    checks++;
    if (cap_q.size() - cb != 1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL abort ack_busy: acks=%0d busy=%b required 1/0", cap_q.size() - cb, busy);
    end
    run_single_frame("after_abort", 0, 8, 1'b0, $urandom, $urandom, 1'b0);
  endtask

  task automatic test_reset_midframe();
    logic [31:0] mr;
    int fb, rb;
    set_tx($urandom);
    select(1, 8, 1'b0);
    clock_bits($urandom, 5, mr);
    fb = n_ferr; rb = rxq.size();
    rst_n = 1'b0;
    #2;
    checks++;
    if ({miso, miso_oe, busy, rx_valid, tx_ack, frame_err} !== 6'b0 || rx_data !== 32'h0) begin
      failures++;
      $display("FAIL midreset_outputs: outs=%b rx_data=%h required 000000/00000000",
               {miso, miso_oe, busy, rx_valid, tx_ack, frame_err}, rx_data);
    end
    cs_n = 1'b1;
    sclk = 1'b0;
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(4);
    checks++;
    if (n_ferr != fb || rxq.size() != rb || busy !== 1'b0) begin
      failures++;
      $display("FAIL midreset_pulses: err=%0d valid=%0d busy=%b required 0/0/0", n_ferr - fb, rxq.size() - rb, busy);
    end
    exp_rx = '0;
    run_single_frame("after_reset", 1, 8, 1'b0, $urandom, $urandom, 1'b0);
  endtask

  initial begin
    spi_config = mk_cfg(0, 8, 1'b0);
    test_reset();
    test_mode0();
    test_modes_16();
    test_lsb32();
    test_back_to_back();
    test_abort();
    test_reset_midframe();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_slave.md
# spi_slave

SPI target that is the far end of the link driven by `spi_master`. It synchronizes externally supplied `sclk`, `cs_n` and `mosi` into the `clk` domain and shifts out a frame from `tx_data` on `miso` while assembling the received frame into `rx_data`. It supports the same SPI modes, frame sizes and bit orders as `spi_master`, sets `busy` while selected, and gives single-cycle pulse handshakes to the host logic.

## Interface
- No parameters. Configuration comes from `spi_config_t`; its `prescaler` field is ignored.
- `clk` in 1: system clock. One clock domain.
- `rst_n` in 1: asynchronous, active-low reset.
- `spi_config` in `spi_config_t`: mode, frame size and bit order. Latched when `cs_n` falls.
- `sclk` in 1: SPI clock from the master. Asynchronous to `clk`.
- `cs_n` in 1: chip select, active low. Asynchronous.
- `mosi` in 1: serial data in. Asynchronous.
- `miso` out 1: serial data out.
- `miso_oe` out 1: high while selected; the pad tristates when low.
- `tx_data` in 32: next frame to transmit, right-aligned.
- `tx_ack` out 1: one-cycle pulse when `tx_data` is captured. The host may change `tx_data` from the next cycle.
- `rx_data` out 32: last complete frame, right-aligned and zero-extended. Held until the next frame completes.
- `rx_valid` out 1: one-cycle pulse when `rx_data` updates.
- `frame_err` out 1: one-cycle pulse when `cs_n` rises mid-frame.
- `busy` out 1: high while selected.

## Operation
- **Synchronization.** `sclk`, `cs_n` and `mosi` each pass through 2 flops, plus a third flop on `sclk` and `cs_n` for edge detection.
  - Reset values: `cs_n` stages 1; all others 0.
- **Edge definitions.** CPOL and CPHA are taken from `spi_mode`: mode 0 = 00, 1 = 01, 2 = 10, 3 = 11.
  - Leading edge: `sclk` moves from CPOL to ~CPOL.
  - Sample edge: leading edge when CPHA=0, trailing edge when CPHA=1.
  - Shift edge: the other edge.
- **Frame length.** N = 8, 16 or 32 from `spi_frame_size` (`SPI_FRAME_SIZE_8/16/32`).
- **States:** IDLE and ACTIVE.
- **IDLE.** All `sclk` edges are ignored, which also suppresses false edges after reset release when CPOL=1. On a `cs_n` fall:
  - latch `spi_config`;
  - load `tx_shift` from `tx_data[N-1:0]` and pulse `tx_ack`;
  - drive the first bit on `miso`: bit N-1 if `MSB_FIRST`, bit 0 if `LSB_FIRST`;
  - set `bit_cnt` = 0 and go to ACTIVE.
- **ACTIVE, sample edge.**
  - Shift synchronized `mosi` into `rx_shift`: into the LSB for MSB-first, into bit N-1 for LSB-first.
  - Increment `bit_cnt`.
  - When the count reaches N:
    - `rx_data` ← the assembled frame, zero-extended, and pulse `rx_valid`;
    - `bit_cnt` ← 0;
    - reload `tx_shift` from `tx_data`, pulse `tx_ack`, and drive the new first bit on `miso`.
  - This supports back-to-back frames under one `cs_n`.
- **ACTIVE, shift edge.**
  - If `bit_cnt` ≠ 0, advance `miso` to the next bit.
  - If `bit_cnt` = 0, do nothing. This covers the CPHA=1 first leading edge and the CPHA=0 trailing edge after frame completion.
- **ACTIVE, `cs_n` rise.**
  - Return to IDLE and discard the partial `rx_shift`.
  - Pulse `frame_err` if `bit_cnt` ≠ 0.
  - `rx_data` is unchanged and `rx_valid` does not pulse.
- **Simultaneous events.** A `cs_n` rise detected in the same cycle as an `sclk` edge takes priority, and the `sclk` edge is dropped.
- **Outputs.**
  - `miso_oe` = `busy` = (state == ACTIVE).
  - `miso` is driven to 0 in IDLE.
- **Config changes** during ACTIVE have no effect until the next `cs_n` fall.
- **Reset.** Asserting `rst_n` at any time, including mid-frame, returns the block to IDLE immediately. No pulses are generated.

## Timing
- **Reset values:** `miso` 0, `miso_oe` 0, `busy` 0, `rx_data` 0, `rx_valid` 0, `tx_ack` 0, `frame_err` 0.
- **Latency.** A pin transition first sampled at `clk` edge k takes effect at edge k+2. This applies to registered outputs (`miso`, `busy`, pulses) and to internal state.
- **Constraint.** The `sclk` half-period must be at least 4 `clk` periods, i.e. `spi_master` prescaler PSC_8 or slower when both share `clk`.
- **Setup.** `cs_n` low to first `sclk` edge must be at least 4 `clk` periods.
- **Pulse spacing.** All pulses are exactly 1 cycle wide. `rx_valid` and `tx_ack` coincide at frame completion.

## Structure
- `spi_config_t`, `spi_mode_t`, `spi_frame_size_t` and `bit_order_t` stay in the shared `defines.vh` package.
  - Add the slave state enum (`SPI_SLV_IDLE`, `SPI_SLV_ACTIVE`) there.
- One sub-module, `sync_edge`: a 3-flop synchronizer with a reset-value parameter and `rise`/`fall` outputs.
  - Instantiated for `sclk` and `cs_n`; `mosi` uses a 2-flop chain.

## Test plan
- **Mode 0, 8-bit, MSB-first.** `spi_master` (PSC_8) sends 0x72 while the slave `tx_data` = 0xA5.
  - Master `rx_data` = 0xA5; slave `rx_data` = 0x72.
  - One `rx_valid` pulse, two `tx_ack` pulses (start and completion), `busy` falls after `cs_n` rises.
- **Modes 1, 2 and 3, 16-bit.** Master sends 0x1234, slave sends 0xBEEF.
  - Both sides receive the other's word in every mode.
  - No false edges when CPOL=1 idles high from reset.
- **LSB-first, 32-bit.** Master sends 0x80000001, slave sends 0xDEADBEEF.
  - Exact word exchange, confirming bit order on both `miso` and `rx_data`.
- **Back-to-back frames.** Two 8-bit frames under one `cs_n` low (0x11 then 0x22).
  - Two `rx_valid` pulses; `rx_data` = 0x11 then 0x22.
  - Second `miso` frame equals the `tx_data` value present at the first `rx_valid`.
- **Abort.** `cs_n` raised after 3 bits of an 8-bit frame.
  - `frame_err` pulses once, no `rx_valid`, `rx_data` keeps its prior value.
  - The next full frame is received correctly.
- **Reset mid-frame.** `rst_n` asserted at bit 5.
  - All outputs return to reset values at once.
  - After release, the next frame completes correctly.
